// File: rtl/npc_pkg.sv
// Shared NPC core package: fetch FSM states, reset PC and
// common instruction/ALU types used across pipeline stages.
package npc_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef logic [31:0] inst_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_VALID,
        S_ERR
    } ifu_state_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_COPY_B
    } alu_op_t;

    function automatic logic word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: holds the architectural PC, issues one word
// read at a time over a valid/ready bus and hands {inst, pc} to decode.
//
// Ports:
//   clk, reset (async, active-high)
//   mem_req_valid/ready/addr   fetch request channel (addr = pc)
//   mem_rsp_valid/ready/data   read data channel
//   out_valid/ready/inst/pc    instruction to decode/execute
//   next_pc                    dnpc, taken on out_valid && out_ready
//   fetch_err                  sticky misaligned-fetch flag
//
// Build option: define IFU_MISALIGN_CHECK_EN to trap fetches from a
// non-word-aligned pc in S_ERR instead of issuing them.
module ifu
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [31:0] mem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output inst_t       out_inst,
    output logic [31:0] out_pc,
    input  logic [31:0] next_pc,
    output logic        fetch_err
);

`ifdef IFU_MISALIGN_CHECK_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    ifu_state_t  state;
    ifu_state_t  state_d;
    logic [31:0] pc;
    inst_t       inst_q;
    logic        pc_load;
    logic        inst_load;
    logic        misalign;

    // Only meaningful with the check built in; otherwise the full pc
    // goes out and memory does its own word alignment.
    assign misalign = MISALIGN_EN && !word_aligned(pc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            inst_q <= '0;
        end else begin
            state <= state_d;
            if (pc_load) begin
                pc <= next_pc;
            end
            if (inst_load) begin
                inst_q <= mem_rsp_data;
            end
        end
    end

    // Handshake outputs decode from registered state (and pc) only;
    // inputs steer nothing but the next-state and load enables.
    always_comb begin
        state_d       = state;
        pc_load       = 1'b0;
        inst_load     = 1'b0;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        out_valid     = 1'b0;
        fetch_err     = 1'b0;
        unique case (state)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (misalign) begin
                    state_d = S_ERR;
                end else begin
                    mem_req_valid = 1'b1;
                    if (mem_req_ready) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                mem_rsp_ready = 1'b1;
                if (mem_rsp_valid) begin
                    inst_load = 1'b1;
                    state_d   = S_VALID;
                end
            end
            S_VALID: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    pc_load = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_ERR: begin
                fetch_err = MISALIGN_EN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // pc and inst_q only change on handshakes, so they are already
    // held stable while the matching valid is up.
    assign mem_req_addr = pc;
    assign out_pc       = pc;
    assign out_inst     = inst_q;

endmodule
